// File: rtl/sr_reg_pkg.sv
// Shared types for the set/reset register bank: runtime modes, handshake FSM states and
// conflict-policy encodings.
package sr_reg_pkg;

  typedef enum logic [1:0] {
    MODE_D      = 2'd0,
    MODE_SR     = 2'd1,
    MODE_FREEZE = 2'd2
  } mode_e;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SWITCH = 1'b1
  } state_e;

  localparam int unsigned POL_HOLD   = 0;
  localparam int unsigned POL_SET    = 1;
  localparam int unsigned POL_CLEAR  = 2;
  localparam int unsigned POL_TOGGLE = 3;

  // The reserved encoding 3 behaves as freeze.
  function automatic mode_e decode_mode(input logic [1:0] req);
    case (req)
      2'd0:    decode_mode = MODE_D;
      2'd1:    decode_mode = MODE_SR;
      default: decode_mode = MODE_FREEZE;
    endcase
  endfunction

endpackage

// File: rtl/sr_bit_cell.sv
// Next-state logic for one stored bit: D load, per-bit set/reset with a configurable
// S=R=1 policy, or hold.
module sr_bit_cell
  import sr_reg_pkg::*;
#(
  parameter int unsigned CONFLICT_POL = POL_HOLD
) (
  input  logic  s,
  input  logic  r,
  input  logic  d,
  input  logic  en,
  input  mode_e mode,
  input  logic  q,
  output logic  q_next
);

  always_comb begin
    q_next = q;
    case (mode)
      MODE_D: begin
        if (en) q_next = d;
      end
      MODE_SR: begin
        case ({s, r})
          2'b10: q_next = 1'b1;
          2'b01: q_next = 1'b0;
          2'b11: begin
            case (CONFLICT_POL)
              POL_SET:    q_next = 1'b1;
              POL_CLEAR:  q_next = 1'b0;
              POL_TOGGLE: q_next = ~q;
              default:    q_next = q;
            endcase
          end
          default: q_next = q;
        endcase
      end
      default: q_next = q;
    endcase
  end

endmodule

// File: rtl/sr_reg_bank.sv
// WIDTH-bit clocked flag bank with D / SR / freeze modes, handshaked mode switching,
// change and conflict flags. SR_REG_BANK_CONFLICT_CNT_EN adds a saturating conflict counter.
module sr_reg_bank
  import sr_reg_pkg::*;
#(
  parameter int unsigned       WIDTH        = 8,
  parameter logic [WIDTH-1:0]  RESET_VAL    = '0,
  parameter int unsigned       CONFLICT_POL = 0,
  parameter int unsigned       CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_d,
  input  logic             in_en,
  input  logic [WIDTH-1:0] in_s,
  input  logic [WIDTH-1:0] in_r,
  input  logic [1:0]       mode_req,
  input  logic             mode_valid,
  output logic             mode_ready,
  output logic [1:0]       mode_cur,
  output logic [WIDTH-1:0] out_q,
  output logic [WIDTH-1:0] out_q_bar,
  output logic             q_changed,
  output logic             conflict
`ifdef SR_REG_BANK_CONFLICT_CNT_EN
  ,
  output logic [CNT_W-1:0] conflict_cnt
`endif
);

  state_e           state_q;
  mode_e            mode_q;
  mode_e            pend_q;
  mode_e            mode_eff;
  logic [WIDTH-1:0] next_q;
  logic             conflict_d;

  // The SWITCH cycle discards data by running the cells as if frozen.
  assign mode_eff   = (state_q == ST_SWITCH) ? MODE_FREEZE : mode_q;
  assign conflict_d = (state_q == ST_RUN) && (mode_q == MODE_SR) && (|(in_s & in_r));

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sr_bit_cell #(
      .CONFLICT_POL(CONFLICT_POL)
    ) u_cell (
      .s     (in_s[i]),
      .r     (in_r[i]),
      .d     (in_d[i]),
      .en    (in_en),
      .mode  (mode_eff),
      .q     (out_q[i]),
      .q_next(next_q[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_RUN;
      mode_q    <= MODE_D;
      pend_q    <= MODE_D;
      out_q     <= RESET_VAL;
      q_changed <= 1'b0;
      conflict  <= 1'b0;
    end else begin
      out_q     <= next_q;
      q_changed <= (next_q != out_q);
      conflict  <= conflict_d;
      case (state_q)
        ST_RUN: begin
          if (mode_valid) begin
            pend_q  <= decode_mode(mode_req);
            state_q <= ST_SWITCH;
          end
        end
        default: begin
          mode_q  <= pend_q;
          state_q <= ST_RUN;
        end
      endcase
    end
  end

  assign mode_ready = (state_q == ST_RUN);
  assign mode_cur   = mode_q;
  assign out_q_bar  = ~out_q;

`ifdef SR_REG_BANK_CONFLICT_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (conflict_d && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign conflict_cnt = cnt_q;
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_sr_reg_bank.sv
// Directed bench for sr_reg_bank: four instances, one per conflict policy, share stimulus;
// expected results are queued at drive time and checked after each edge.
module tb_sr_reg_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_d, in_s, in_r;
  logic       in_en;
  logic [1:0] mode_req;
  logic       mode_valid;

  logic       mode_ready [4];
  logic [1:0] mode_cur   [4];
  logic [7:0] out_q      [4];
  logic [7:0] out_q_bar  [4];
  logic       q_changed  [4];
  logic       conflict   [4];
  logic [1:0] conflict_cnt [4];

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    logic [7:0] q   [4];
    logic [3:0] chg;
    logic       cfl;
    logic [1:0] mode;
    logic       rdy;
    logic [1:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t cur;

  always #5 clk = ~clk;

  for (genvar p = 0; p < 4; p++) begin : g_dut
    sr_reg_bank #(
      .WIDTH       (8),
      .RESET_VAL   (8'hA5),
      .CONFLICT_POL(p),
      .CNT_W       (2)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .in_d      (in_d),
      .in_en     (in_en),
      .in_s      (in_s),
      .in_r      (in_r),
      .mode_req  (mode_req),
      .mode_valid(mode_valid),
      .mode_ready(mode_ready[p]),
      .mode_cur  (mode_cur[p]),
      .out_q     (out_q[p]),
      .out_q_bar (out_q_bar[p]),
      .q_changed (q_changed[p]),
      .conflict  (conflict[p])
`ifdef SR_REG_BANK_CONFLICT_CNT_EN
      ,
      .conflict_cnt(conflict_cnt[p])
`endif
    );
`ifndef SR_REG_BANK_CONFLICT_CNT_EN
    assign conflict_cnt[p] = 2'd0;
`endif
  end

  task automatic chk(input string tag, input int p, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s[pol%0d]: observed=%h expected=%h", tag, p, obs, exp);
    end
  endtask

  // Queue an expectation with a common q and change flag for all four policies.
  task automatic push(input string tag, input logic [7:0] q, input logic [3:0] chg,
                      input logic cfl, input logic [1:0] mode, input logic rdy,
                      input logic [1:0] cnt);
    exp_t e;
    e.tag = tag;
    for (int p = 0; p < 4; p++) e.q[p] = q;
    e.chg = chg; e.cfl = cfl; e.mode = mode; e.rdy = rdy; e.cnt = cnt;
    sb.push_back(e);
  endtask

  task automatic step_and_check();
    exp_t e;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    for (int p = 0; p < 4; p++) begin
      chk({e.tag, ".q"},     p, out_q[p],     e.q[p]);
      chk({e.tag, ".qbar"},  p, out_q_bar[p], ~e.q[p]);
      chk({e.tag, ".chg"},   p, {7'd0, q_changed[p]},  {7'd0, e.chg[p]});
      chk({e.tag, ".cfl"},   p, {7'd0, conflict[p]},   {7'd0, e.cfl});
      chk({e.tag, ".mode"},  p, {6'd0, mode_cur[p]},   {6'd0, e.mode});
      chk({e.tag, ".rdy"},   p, {7'd0, mode_ready[p]}, {7'd0, e.rdy});
`ifdef SR_REG_BANK_CONFLICT_CNT_EN
      chk({e.tag, ".cnt"},   p, {6'd0, conflict_cnt[p]}, {6'd0, e.cnt});
`endif
    end
  endtask

  initial begin
    reset = 1'b0; in_d = 8'h00; in_en = 1'b0; in_s = 8'h00; in_r = 8'h00;
    mode_req = 2'd0; mode_valid = 1'b0;

    // Reset
    push("reset", 8'hA5, 4'b0000, 1'b0, 2'd0, 1'b1, 2'd0);
    step_and_check();

    // D mode load, then hold with enable low
    reset = 1'b1; in_d = 8'h3C; in_en = 1'b1;
    push("d_load", 8'h3C, 4'b1111, 1'b0, 2'd0, 1'b1, 2'd0);
    step_and_check();
    in_d = 8'hFF; in_en = 1'b0;
    push("d_hold", 8'h3C, 4'b0000, 1'b0, 2'd0, 1'b1, 2'd0);
    step_and_check();

    // Request SR mode
    mode_req = 2'd1; mode_valid = 1'b1;
    push("req_sr", 8'h3C, 4'b0000, 1'b0, 2'd0, 1'b0, 2'd0);
    step_and_check();
    // SWITCH edge: data discarded, a competing request is not queued
    mode_req = 2'd0; in_en = 1'b1; in_d = 8'hFF;
    push("switch_sr", 8'h3C, 4'b0000, 1'b0, 2'd1, 1'b1, 2'd0);
    step_and_check();
    mode_valid = 1'b0;

    // SR clear all; in_d/in_en ignored
    in_d = 8'h77; in_s = 8'h00; in_r = 8'hFF;
    push("sr_clear", 8'h00, 4'b1111, 1'b0, 2'd1, 1'b1, 2'd0);
    step_and_check();

    // Five consecutive conflict cycles: in_s=0F, in_r=03
    in_s = 8'h0F; in_r = 8'h03;
    for (int k = 0; k < 5; k++) begin
      exp_t e;
      e.tag  = $sformatf("conflict%0d", k);
      e.q[0] = 8'h0C;
      e.q[1] = 8'h0F;
      e.q[2] = 8'h0C;
      e.q[3] = (k % 2 == 0) ? 8'h0F : 8'h0C;
      e.chg  = (k == 0) ? 4'b1111 : 4'b1000;
      e.cfl  = 1'b1;
      e.mode = 2'd1;
      e.rdy  = 1'b1;
      e.cnt  = (k >= 2) ? 2'd3 : 2'(k + 1);
      sb.push_back(e);
      step_and_check();
    end

    // SR hold: flag drops, counter stays saturated
    in_s = 8'h00; in_r = 8'h00;
    cur.tag = "sr_hold";
    cur.q[0] = 8'h0C; cur.q[1] = 8'h0F; cur.q[2] = 8'h0C; cur.q[3] = 8'h0F;
    cur.chg = 4'b0000; cur.cfl = 1'b0; cur.mode = 2'd1; cur.rdy = 1'b1; cur.cnt = 2'd3;
    sb.push_back(cur);
    step_and_check();

    // Go to FREEZE
    mode_req = 2'd2; mode_valid = 1'b1;
    cur.tag = "req_frz"; cur.rdy = 1'b0;
    sb.push_back(cur);
    step_and_check();
    mode_valid = 1'b0; in_s = 8'hFF;
    cur.tag = "switch_frz"; cur.rdy = 1'b1; cur.mode = 2'd2;
    sb.push_back(cur);
    step_and_check();
    in_en = 1'b1; in_d = 8'h00; in_r = 8'h00;
    cur.tag = "frz_hold";
    sb.push_back(cur);
    step_and_check();

    // Reserved mode request maps to FREEZE
    mode_req = 2'd3; mode_valid = 1'b1;
    cur.tag = "req_rsv"; cur.rdy = 1'b0;
    sb.push_back(cur);
    step_and_check();
    mode_valid = 1'b0;
    cur.tag = "switch_rsv"; cur.rdy = 1'b1;
    sb.push_back(cur);
    step_and_check();

    // Reset during SWITCH drops the pending mode
    mode_req = 2'd1; mode_valid = 1'b1;
    cur.tag = "req_sr2"; cur.rdy = 1'b0;
    sb.push_back(cur);
    step_and_check();
    reset = 1'b0; mode_valid = 1'b0; in_en = 1'b1; in_d = 8'h00;
    push("reset_sw", 8'hA5, 4'b0000, 1'b0, 2'd0, 1'b1, 2'd0);
    step_and_check();

    // Back in D mode after reset
    reset = 1'b1; in_d = 8'h5A; in_s = 8'h00;
    push("d_after_rst", 8'h5A, 4'b1111, 1'b0, 2'd0, 1'b1, 2'd0);
    step_and_check();

    if (sb.size() != 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard: observed=%0d leftover expected=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
